arp_rx: RTL and testbench



---
 rtl/arp_rx.sv | 217 +++++++++++++++++++++
 tb/tb_arp_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_rx.sv
// ARP request receiver: parses Ethernet frames from the destination MAC onward and,
// on a valid ARP request for the local IP, holds the sender MAC/IP with a level request.
module arp_rx (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_sof,
    input  logic       i_rx_eof,
    input  logic       i_rx_err,
    input  logic [7:0] i_local_mac0,
    input  logic [7:0] i_local_mac1,
    input  logic [7:0] i_local_mac2,
    input  logic [7:0] i_local_mac3,
    input  logic [7:0] i_local_mac4,
    input  logic [7:0] i_local_mac5,
    input  logic [7:0] i_local_ip0,
    input  logic [7:0] i_local_ip1,
    input  logic [7:0] i_local_ip2,
    input  logic [7:0] i_local_ip3,
    input  logic       i_ack,
    output logic [7:0] o_mac0,
    output logic [7:0] o_mac1,
    output logic [7:0] o_mac2,
    output logic [7:0] o_mac3,
    output logic [7:0] o_mac4,
    output logic [7:0] o_mac5,
    output logic [7:0] o_ip0,
    output logic [7:0] o_ip1,
    output logic [7:0] o_ip2,
    output logic [7:0] o_ip3,
    output logic       o_req
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_SKIP,
        ST_HOLD
    } state_t;

    localparam logic [5:0] CNT_MAX = 6'd42;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       bcast_q, bcast_d;
    logic       ucast_q, ucast_d;
    logic [7:0] sha_q [6];
    logic [7:0] sha_d [6];
    logic [7:0] spa_q [4];
    logic [7:0] spa_d [4];
    logic [7:0] mac_q [6];
    logic [7:0] ip_q  [4];
    logic       req_q, req_d;
    logic       load;
    logic [5:0] idx;
    logic [7:0] mac_exp;
    logic       byte_ok;

    // A sof byte is always index 0, even when it interrupts a frame in progress.
    assign idx = i_rx_sof ? 6'd0 : cnt_q;

    always_comb begin
        mac_exp = 8'h00;
        case (idx)
            6'd0:    mac_exp = i_local_mac0;
            6'd1:    mac_exp = i_local_mac1;
            6'd2:    mac_exp = i_local_mac2;
            6'd3:    mac_exp = i_local_mac3;
            6'd4:    mac_exp = i_local_mac4;
            6'd5:    mac_exp = i_local_mac5;
            default: mac_exp = 8'h00;
        endcase
    end

    // Destination MAC may be broadcast or ours; both candidates are tracked until byte 5.
    always_comb begin
        byte_ok = 1'b1;
        bcast_d = bcast_q;
        ucast_d = ucast_q;
        if (i_rx_valid && (idx <= 6'd5)) begin
            bcast_d = ((idx == 6'd0) || bcast_q) && (i_rx_data == 8'hFF);
            ucast_d = ((idx == 6'd0) || ucast_q) && (i_rx_data == mac_exp);
            if ((idx == 6'd5) && !bcast_d && !ucast_d) begin
                byte_ok = 1'b0;
            end
        end
        case (idx)
            6'd12:   byte_ok = (i_rx_data == 8'h08);
            6'd13:   byte_ok = (i_rx_data == 8'h06);
            6'd14:   byte_ok = (i_rx_data == 8'h00);
            6'd15:   byte_ok = (i_rx_data == 8'h01);
            6'd16:   byte_ok = (i_rx_data == 8'h08);
            6'd17:   byte_ok = (i_rx_data == 8'h00);
            6'd18:   byte_ok = (i_rx_data == 8'h06);
            6'd19:   byte_ok = (i_rx_data == 8'h04);
            6'd20:   byte_ok = (i_rx_data == 8'h00);
            6'd21:   byte_ok = (i_rx_data == 8'h01);
            6'd38:   byte_ok = (i_rx_data == i_local_ip0);
            6'd39:   byte_ok = (i_rx_data == i_local_ip1);
            6'd40:   byte_ok = (i_rx_data == i_local_ip2);
            6'd41:   byte_ok = (i_rx_data == i_local_ip3);
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sha_d   = sha_q;
        spa_d   = spa_q;
        req_d   = req_q;
        load    = 1'b0;

        if (i_rx_valid) begin
            if (i_rx_sof) begin
                cnt_d = 6'd1;
            end else if (cnt_q >= CNT_MAX) begin
                cnt_d = CNT_MAX;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid && i_rx_sof && !i_rx_eof) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (i_rx_valid) begin
                    case (idx)
                        6'd22:   sha_d[0] = i_rx_data;
                        6'd23:   sha_d[1] = i_rx_data;
                        6'd24:   sha_d[2] = i_rx_data;
                        6'd25:   sha_d[3] = i_rx_data;
                        6'd26:   sha_d[4] = i_rx_data;
                        6'd27:   sha_d[5] = i_rx_data;
                        6'd28:   spa_d[0] = i_rx_data;
                        6'd29:   spa_d[1] = i_rx_data;
                        6'd30:   spa_d[2] = i_rx_data;
                        6'd31:   spa_d[3] = i_rx_data;
                        default: ;
                    endcase
                    if (i_rx_eof) begin
                        if ((idx >= 6'd41) && !i_rx_err && byte_ok) begin
                            state_d = ST_HOLD;
                            req_d   = 1'b1;
                            load    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (!byte_ok) begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (i_rx_valid) begin
                    if (i_rx_eof) begin
                        state_d = ST_IDLE;
                    end else if (i_rx_sof) begin
                        state_d = ST_RECV;
                    end
                end
            end
            ST_HOLD: begin
                if (i_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            bcast_q <= 1'b0;
            ucast_q <= 1'b0;
            sha_q   <= '{default: 8'h00};
            spa_q   <= '{default: 8'h00};
            mac_q   <= '{default: 8'h00};
            ip_q    <= '{default: 8'h00};
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcast_q <= bcast_d;
            ucast_q <= ucast_d;
            sha_q   <= sha_d;
            spa_q   <= spa_d;
            req_q   <= req_d;
            // Published address only changes when a request is accepted.
            if (load) begin
                mac_q <= sha_q;
                ip_q  <= spa_q;
            end
        end
    end

    assign o_mac0 = mac_q[0];
    assign o_mac1 = mac_q[1];
    assign o_mac2 = mac_q[2];
    assign o_mac3 = mac_q[3];
    assign o_mac4 = mac_q[4];
    assign o_mac5 = mac_q[5];
    assign o_ip0  = ip_q[0];
    assign o_ip1  = ip_q[1];
    assign o_ip2  = ip_q[2];
    assign o_ip3  = ip_q[3];
    assign o_req  = req_q;

endmodule

// File: tb/tb_arp_rx.sv
// Bench for arp_rx: frame-level reference model compared against the DUT every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_arp_rx;

    localparam logic [47:0] LMAC = 48'h02_00_00_AA_BB_01;
    localparam logic [31:0] LIP  = 32'hC0_A8_01_02;
    localparam logic [47:0] BC   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SHA1 = 48'h00_11_22_33_44_55;
    localparam logic [31:0] SPA1 = 32'hC0_A8_01_0A;
    localparam logic [47:0] SHA2 = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [31:0] SPA2 = 32'h0A_00_00_01;
    localparam logic [47:0] SHA3 = 48'h66_55_44_33_22_11;
    localparam logic [31:0] SPA3 = 32'h0A_0A_0A_0A;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       i_rx_sof;
    logic       i_rx_eof;
    logic       i_rx_err;
    logic       i_ack;
    logic [7:0] o_mac0, o_mac1, o_mac2, o_mac3, o_mac4, o_mac5;
    logic [7:0] o_ip0, o_ip1, o_ip2, o_ip3;
    logic       o_req;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: frame buffer plus the pending captured address.
    logic        mPending;
    logic        mInFrame;
    logic [47:0] mMac;
    logic [31:0] mIp;
    logic [7:0]  mBuf[$];
    logic [7:0]  frm[$];

    arp_rx dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .i_rx_sof     (i_rx_sof),
        .i_rx_eof     (i_rx_eof),
        .i_rx_err     (i_rx_err),
        .i_local_mac0 (LMAC[47:40]),
        .i_local_mac1 (LMAC[39:32]),
        .i_local_mac2 (LMAC[31:24]),
        .i_local_mac3 (LMAC[23:16]),
        .i_local_mac4 (LMAC[15:8]),
        .i_local_mac5 (LMAC[7:0]),
        .i_local_ip0  (LIP[31:24]),
        .i_local_ip1  (LIP[23:16]),
        .i_local_ip2  (LIP[15:8]),
        .i_local_ip3  (LIP[7:0]),
        .i_ack        (i_ack),
        .o_mac0       (o_mac0),
        .o_mac1       (o_mac1),
        .o_mac2       (o_mac2),
        .o_mac3       (o_mac3),
        .o_mac4       (o_mac4),
        .o_mac5       (o_mac5),
        .o_ip0        (o_ip0),
        .o_ip1        (o_ip1),
        .o_ip2        (o_ip2),
        .o_ip3        (o_ip3),
        .o_req        (o_req)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [80:0] dutVec();
        return {o_req, o_mac0, o_mac1, o_mac2, o_mac3, o_mac4, o_mac5,
                o_ip0, o_ip1, o_ip2, o_ip3};
    endfunction

    function automatic logic [80:0] modelVec();
        return {mPending, mMac, mIp};
    endfunction

    // A frame is a valid request when every ARP rule holds over the bytes received.
    function automatic bit frameOk(input logic er);
        logic [47:0] lmac;
        logic [31:0] lip;
        logic [79:0] hdr;
        bit bc, uc;
        lmac = LMAC;
        lip  = LIP;
        hdr  = 80'h0806_0001_0800_06_04_0001;
        if (er || mBuf.size() < 42) return 1'b0;
        bc = 1'b1;
        uc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (mBuf[i] !== 8'hFF) bc = 1'b0;
            if (mBuf[i] !== lmac[47-8*i -: 8]) uc = 1'b0;
        end
        if (!bc && !uc) return 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mBuf[12+i] !== hdr[79-8*i -: 8]) return 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (mBuf[38+i] !== lip[31-8*i -: 8]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelReset();
        mPending = 1'b0;
        mInFrame = 1'b0;
        mMac     = '0;
        mIp      = '0;
        mBuf.delete();
    endtask

    task automatic modelStep(input logic v, input logic [7:0] d, input logic s,
                             input logic e, input logic er, input logic a);
        if (mPending) begin
            mInFrame = 1'b0;
            if (a) mPending = 1'b0;
            return;
        end
        if (!v) return;
        if (s) begin
            mBuf.delete();
            mBuf.push_back(d);
            mInFrame = 1'b1;
        end else if (mInFrame) begin
            mBuf.push_back(d);
        end
        if (e && mInFrame) begin
            mInFrame = 1'b0;
            if (frameOk(er)) begin
                mPending = 1'b1;
                for (int i = 0; i < 6; i++) mMac[47-8*i -: 8] = mBuf[22+i];
                for (int i = 0; i < 4; i++) mIp[31-8*i -: 8] = mBuf[28+i];
            end
        end
    endtask

    always @(negedge i_clk) begin
        vectors++;
        if (dutVec() !== modelVec()) begin
            miscompares++;
            $display("[TB] FAIL cycle_compare @%0t: got %h expected %h", $time, dutVec(), modelVec());
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s,
                                 input logic e, input logic er, input logic a);
        i_rx_valid = v;
        i_rx_data  = d;
        i_rx_sof   = s;
        i_rx_eof   = e;
        i_rx_err   = er;
        i_ack      = a;
        @(posedge i_clk);
        #1;
        if (i_rst_n) modelStep(v, d, s, e, er, a);
    endtask

    task automatic checkOutput(input string name, input logic [80:0] exp);
        vectors++;
        if (dutVec() !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, dutVec(), exp);
        end
    endtask

    task automatic idle(input int n, input bit randAck);
        repeat (n) applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                 randAck ? 1'($urandom) : 1'b0);
    endtask

    task automatic doAck();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic makeFrame(input logic [47:0] dst, input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa, input logic [15:0] etype,
                             input logic [15:0] op, input int len);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        frm.push_back(8'h00);
        frm.push_back(8'h01);
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        frm.push_back(8'h06);
        frm.push_back(8'h04);
        frm.push_back(op[15:8]);
        frm.push_back(op[7:0]);
        for (int i = 0; i < 6; i++) frm.push_back(sha[47-8*i -: 8]);
        for (int i = 0; i < 4; i++) frm.push_back(spa[31-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) frm.push_back(tpa[31-8*i -: 8]);
        while (frm.size() < len) frm.push_back(8'($urandom));
        while (frm.size() > len) void'(frm.pop_back());
    endtask

    task automatic sendFrame(input int gapMax, input bit randAck, input logic err, input bit withEof);
        bit last;
        for (int i = 0; i < frm.size(); i++) begin
            if (i != 0) begin
                repeat ($urandom_range(0, gapMax)) applyStimulus(1'b0, 8'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), randAck ? 1'($urandom) : 1'b0);
            end
            last = (i == frm.size() - 1);
            applyStimulus(1'b1, frm[i], i == 0, last && withEof, last ? err : 1'($urandom),
                          randAck ? 1'($urandom) : 1'b0);
        end
    endtask

    initial begin
        int len, k;
        logic [47:0] dst, sha;
        logic [31:0] spa, tpa;
        logic err;
        bit withEof;

        i_rst_n    = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_sof   = 1'b0;
        i_rx_eof   = 1'b0;
        i_rx_err   = 1'b0;
        i_ack      = 1'b0;
        modelReset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        checkOutput("reset_state", 81'h0);

        $display("[TB] broadcast request");
        makeFrame(BC, SHA1, SPA1, LIP, 16'h0806, 16'h0001, 60);
        sendFrame(0, 1'b0, 1'b0, 1'b1);
        checkOutput("bcast_accept", {1'b1, SHA1, SPA1});
        idle(3, 1'b0);
        checkOutput("hold_until_ack", {1'b1, SHA1, SPA1});
        doAck();
        checkOutput("ack_clears_req", {1'b0, SHA1, SPA1});

        $display("[TB] rejected frames");
        for (int kind = 0; kind < 5; kind++) begin
            dst = (kind == 3) ? 48'h02_00_00_AA_BB_02 : BC;
            tpa = (kind == 2) ? 32'hC0_A8_01_03 : LIP;
            makeFrame(dst, SHA2, SPA2, tpa, (kind == 1) ? 16'h0800 : 16'h0806,
                      (kind == 0) ? 16'h0002 : 16'h0001, 60);
            sendFrame(1, 1'b0, kind == 4, 1'b1);
            idle(2, 1'b1);
        end
        checkOutput("rejects_keep_outputs", {1'b0, SHA1, SPA1});

        makeFrame(LMAC, SHA2, SPA2, LIP, 16'h0806, 16'h0001, 60);
        sendFrame(1, 1'b0, 1'b0, 1'b1);
        checkOutput("ucast_accept", {1'b1, SHA2, SPA2});
        doAck();

        $display("[TB] short frames");
        makeFrame(BC, SHA1, SPA1, LIP, 16'h0806, 16'h0001, 41);
        sendFrame(0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        checkOutput("short_41_rejected", {1'b0, SHA2, SPA2});
        makeFrame(BC, SHA1, SPA1, LIP, 16'h0806, 16'h0001, 42);
        sendFrame(0, 1'b0, 1'b0, 1'b1);
        checkOutput("min_42_accepted", {1'b1, SHA1, SPA1});
        doAck();

        $display("[TB] restart and back-to-back");
        makeFrame(BC, SHA2, SPA2, LIP, 16'h0806, 16'h0001, 15);
        sendFrame(0, 1'b0, 1'b0, 1'b0);
        makeFrame(BC, SHA3, SPA3, LIP, 16'h0806, 16'h0001, 60);
        sendFrame(0, 1'b0, 1'b0, 1'b1);
        checkOutput("restart_accept", {1'b1, SHA3, SPA3});
        doAck();
        makeFrame(BC, SHA1, SPA1, LIP, 16'h0806, 16'h0002, 60);
        sendFrame(0, 1'b0, 1'b0, 1'b1);
        makeFrame(BC, SHA2, SPA2, LIP, 16'h0806, 16'h0001, 60);
        sendFrame(0, 1'b0, 1'b0, 1'b1);
        checkOutput("back_to_back_accept", {1'b1, SHA2, SPA2});

        $display("[TB] frames while pending");
        makeFrame(BC, 48'hAA_BB_CC_DD_EE_FF, SPA1, LIP, 16'h0806, 16'h0001, 60);
        sendFrame(0, 1'b0, 1'b0, 1'b1);
        checkOutput("pending_drops_frame", {1'b1, SHA2, SPA2});
        doAck();
        checkOutput("pending_ack", {1'b0, SHA2, SPA2});
        makeFrame(BC, SHA1, SPA1, LIP, 16'h0806, 16'h0001, 60);
        sendFrame(0, 1'b0, 1'b0, 1'b1);
        checkOutput("after_pending_accept", {1'b1, SHA1, SPA1});
        doAck();

        $display("[TB] reset mid-frame");
        makeFrame(BC, SHA3, SPA3, LIP, 16'h0806, 16'h0001, 60);
        for (int i = 0; i < 25; i++)
            applyStimulus(1'b1, frm[i], i == 0, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_async_clear", 81'h0);
        for (int i = 25; i < 27; i++)
            applyStimulus(1'b1, frm[i], 1'b0, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        for (int i = 27; i < 60; i++)
            applyStimulus(1'b1, frm[i], 1'b0, i == 59, 1'b0, 1'b0);
        idle(1, 1'b0);
        checkOutput("reset_remainder_ignored", 81'h0);

        $display("[TB] randomized frames");
        repeat (60) begin
            len = $urandom_range(36, 70);
            dst = ($urandom_range(0, 3) == 0) ? LMAC : BC;
            if ($urandom_range(0, 9) == 0) dst = {16'($urandom), 32'($urandom)};
            sha = {16'($urandom), 32'($urandom)};
            spa = 32'($urandom);
            tpa = ($urandom_range(0, 5) == 0) ? 32'($urandom) : LIP;
            makeFrame(dst, sha, spa, tpa, 16'h0806, 16'h0001, len);
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, (len < 42) ? len - 1 : 41);
                frm[k] = frm[k] ^ 8'($urandom_range(1, 255));
            end
            err     = ($urandom_range(0, 7) == 0);
            withEof = ($urandom_range(0, 9) != 0);
            sendFrame(2, 1'b1, err, withEof);
            idle($urandom_range(0, 3), 1'b1);
        end
        idle(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
